// File: rtl/serial_shifter_if.sv
// serial_shifter_if: request/response bundle between the execute-stage
// datapath (master) and the serial shift unit (slave).
//   master drives start/op/data_in/sa32 and observes busy/done/result.
//   sa32 is the zero-extended shift amount from decode; the unit only
//   looks at bits [4:0].
interface serial_shifter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] data_in;
    logic [31:0]      sa32;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start,
        output op,
        output data_in,
        output sa32,
        input  busy,
        input  done,
        input  result
    );

    modport slave (
        input  start,
        input  op,
        input  data_in,
        input  sa32,
        output busy,
        output done,
        output result
    );
endinterface

// File: rtl/serial_shifter.sv
// serial_shifter: multi-cycle SLL/SRL/SRA/ROR unit, one bit position per clock.
//
// Optional build macro: SERIAL_SHIFTER_BARREL_EN
//   undefined (default): serial shifting, latency n = sa32[4:0] edges.
//   defined: a combinational barrel shifter produces the result at the
//            accepting edge; SHIFT is never entered, busy stays low, and
//            done pulses in the cycle right after acceptance.
//
// Reset is synchronous and active-high; it dominates start and aborts a
// shift in progress without a done pulse.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start; result holds the last value
// S_SHIFT | shifting work_q one position per edge, cnt_q counting down
// S_DONE  | one-cycle done pulse; a new start is accepted here as well
module serial_shifter #(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           rst,
    serial_shifter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // only 32-bit operands are supported; the datapath below is fixed at 32
    localparam int W = 32;

    state_t         state_q;
    logic [W-1:0]   work_q;
    logic [1:0]     op_q;
    logic [4:0]     cnt_q;
    logic           busy_q;
    logic           done_q;
    logic [W-1:0]   result_q;

    logic           accept_d;
    logic [4:0]     sa_d;
    logic [W-1:0]   work_d;
    logic           unused_sa_hi;

    // one-position shift of the working register for the captured op
    function automatic logic [W-1:0] step1(input logic [1:0] op, input logic [W-1:0] x);
        logic [W-1:0] y;
        case (op)
            2'b00:   y = {x[W-2:0], 1'b0};
            2'b01:   y = {1'b0, x[W-1:1]};
            2'b10:   y = {x[W-1], x[W-1:1]};
            default: y = {x[0], x[W-1:1]};
        endcase
        return y;
    endfunction

`ifdef SERIAL_SHIFTER_BARREL_EN
    // full-distance shift in one step; ROR is the low half of {x,x} >> n
    function automatic logic [W-1:0] barrel(input logic [1:0] op, input logic [W-1:0] x,
                                            input logic [4:0] n);
        logic [2*W-1:0] dbl;
        logic [W-1:0]   y;
        dbl = {x, x} >> n;
        case (op)
            2'b00:   y = x << n;
            2'b01:   y = x >> n;
            2'b10:   y = W'($signed(x) >>> n);
            default: y = dbl[W-1:0];
        endcase
        return y;
    endfunction
`endif

    // request acceptance and next working value
    always_comb begin
        accept_d     = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
        sa_d         = bus.sa32[4:0];
        work_d       = step1(op_q, work_q);
        unused_sa_hi = ^bus.sa32[31:5];
    end

    // control FSM with registered busy/done/result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            work_q   <= '0;
            op_q     <= 2'b00;
            cnt_q    <= 5'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept_d) begin
                        work_q <= bus.data_in;
                        op_q   <= bus.op;
                        cnt_q  <= sa_d;
`ifdef SERIAL_SHIFTER_BARREL_EN
                        result_q <= barrel(bus.op, bus.data_in, sa_d);
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
`else
                        result_q <= bus.data_in;
                        if (sa_d == 5'd0) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_SHIFT;
                            busy_q  <= 1'b1;
                        end
`endif
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    work_q   <= work_d;
                    result_q <= work_d;
                    cnt_q    <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_serial_shifter.sv
// tb_serial_shifter: scoreboard bench for serial_shifter.
// The stimulus side pushes {expected result, expected done edge} when it
// issues a request; a monitor on the falling edge pops on every done pulse
// and also checks busy against the window the model predicts.
module tb_serial_shifter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    serial_shifter_if bus ();

    serial_shifter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] res;
        int          done_edge;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   checks   = 0;
    int   passed   = 0;
    int   busy_lo  = 0;
    int   busy_hi  = 0;
    bit   mon_en   = 1'b0;

    always @(posedge clk) edge_cnt++;

    // shift semantics straight from the op definitions
    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] x, input int n);
        logic [63:0] dbl;
        logic [63:0] rot;
        dbl = {x, x};
        rot = dbl >> n;
        case (op)
            2'b00:   return x << n;
            2'b01:   return x >> n;
            2'b10:   return 32'($signed(x) >>> n);
            default: return rot[31:0];
        endcase
    endfunction

    function automatic int lat_of(input int n);
`ifdef SERIAL_SHIFTER_BARREL_EN
        return 0;
`else
        return n;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // called at posedge+1 with the unit in IDLE or DONE; returns after the accepting edge
    task automatic issue(input logic [1:0] op, input logic [31:0] d, input logic [31:0] sa,
                         output int lat);
        int   k;
        int   n;
        exp_t e;
        n = int'(sa[4:0]);
        lat = lat_of(n);
        k = edge_cnt + 1;
        e.res = ref_shift(op, d, n);
        e.done_edge = k + lat;
        sb.push_back(e);
        busy_lo = k;
        busy_hi = k + lat;
        bus.op = op;
        bus.data_in = d;
        bus.sa32 = sa;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.data_in = $urandom;
        bus.op = 2'($urandom);
        bus.sa32 = $urandom;
    endtask

    task automatic drain(input int budget);
        int t;
        t = 0;
        while (sb.size() != 0 && t < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout: %0d requests still pending after %0d cycles", sb.size(), budget);
            sb.delete();
        end
    endtask

    // monitor: busy window every cycle, result/latency on every done
    always @(negedge clk) begin
        exp_t e;
        logic exp_busy;
        if (mon_en) begin
            exp_busy = (edge_cnt >= busy_lo) && (edge_cnt < busy_hi);
            checks++;
            if (bus.busy === exp_busy) passed++;
            else $display("FAIL busy @edge %0d: got %b, expected %b", edge_cnt, bus.busy, exp_busy);
            if (bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_done @edge %0d: result 0x%08h, no request pending", edge_cnt, bus.result);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (e.done_edge == edge_cnt) passed++;
                    else $display("FAIL latency: done at edge %0d, expected edge %0d", edge_cnt, e.done_edge);
                    check("result", bus.result, e.res);
                end
            end else if (bus.done !== 1'b0) begin
                checks++;
                $display("FAIL done_level @edge %0d: got %b, expected 0 or 1", edge_cnt, bus.done);
            end else if (sb.size() != 0 && edge_cnt >= sb[0].done_edge) begin
                e = sb.pop_front();
                checks++;
                $display("FAIL missing_done: no pulse by edge %0d, expected at edge %0d", edge_cnt, e.done_edge);
            end
        end
    end

    initial begin
        int lat;
        int lat2;
        logic [1:0]  rop;
        logic [31:0] rd;
        logic [31:0] rsa;

        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.data_in = '0;
        bus.sa32 = '0;

        // reset then idle
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_result", bus.result, 32'h0000_0000);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // directed cases
        issue(2'b00, 32'h0000_0001, 32'h0000_0004, lat);
        drain(100);
        check("sll_hold", bus.result, 32'h0000_0010);

        issue(2'b10, 32'h8000_0000, 32'd31, lat);
        drain(100);
        check("sra31_hold", bus.result, 32'hFFFF_FFFF);

        issue(2'b11, 32'h0000_0001, 32'd1, lat);
        drain(100);
        check("ror1_hold", bus.result, 32'h8000_0000);

        issue(2'b01, 32'h1234_5678, 32'h0000_0020, lat);
        drain(100);
        check("sa_hi_ignored", bus.result, 32'h1234_5678);

        // ignored start during SHIFT, then back-to-back from DONE
        issue(2'b00, 32'h0000_0003, 32'd10, lat);
`ifndef SERIAL_SHIFTER_BARREL_EN
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op = 2'b11;
        bus.data_in = 32'hDEAD_BEEF;
        bus.sa32 = 32'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (lat - 2) @(posedge clk);
        #1;
`endif
        issue(2'b01, 32'hF000_0000, 32'd4, lat2);
        drain(100);
        check("b2b_hold", bus.result, 32'h0F00_0000);

        // reset in the middle of a shift
        issue(2'b01, 32'hCAFE_F00D, 32'd10, lat);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        if (busy_hi > edge_cnt + 1) busy_hi = edge_cnt + 1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_result", bus.result, 32'h0000_0000);
        repeat (12) @(posedge clk);
        #1;
        issue(2'b10, 32'h4000_0000, 32'd3, lat);
        drain(100);
        check("after_abort", bus.result, 32'h0800_0000);

        // randomized traffic, mixing idle gaps and back-to-back issue
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            rd  = $urandom;
            rsa = $urandom;
            if ($urandom_range(3, 0) == 0) rsa[4:0] = 5'(i % 3);
            issue(rop, rd, rsa, lat);
            if ($urandom_range(1, 0) == 1) begin
                repeat (lat) @(posedge clk);
                #1;
            end else begin
                drain(100);
                repeat ($urandom_range(3, 0)) @(posedge clk);
                #1;
            end
        end
        drain(100);
        repeat (3) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
